// File: rtl/asi_rw_arb_pkg.sv
// Shared types and policy encodings for the asi read/write port arbiter.
package asi_rw_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_W    = 2'd1,
        OWN_R    = 2'd2
    } arb_owner_e;

    localparam int ARB_RR   = 0;
    localparam int ARB_WPRI = 1;
    localparam int ARB_RPRI = 2;

    // Resolves a simultaneous request; a pending cap handover overrides the policy once.
    function automatic logic tie_to_w(input int policy, input arb_owner_e favor,
                                      input arb_owner_e last);
        if (favor == OWN_W) return 1'b1;
        if (favor == OWN_R) return 1'b0;
        case (policy)
            ARB_WPRI: return 1'b1;
            ARB_RPRI: return 1'b0;
            default:  return (last == OWN_R);
        endcase
    endfunction

endpackage

// File: rtl/asi_rw_arb_if.sv
// Request/busy/beat strobes from asi_w/asi_r and the grants and status returned by the arbiter.
interface asi_rw_arb_if;
    import asi_rw_arb_pkg::*;

    logic       m_awff_rvalid;
    logic       m_wbusy;
    logic       m_we;
    logic       m_wlast;
    logic       m_arff_rvalid;
    logic       m_rbusy;
    logic       m_re;
    logic       m_rlast;
    logic       wgranted;
    logic       rgranted;
    arb_owner_e arb_owner;
    logic       arb_err;

    modport master (
        output m_awff_rvalid, m_wbusy, m_we, m_wlast,
        output m_arff_rvalid, m_rbusy, m_re, m_rlast,
        input  wgranted, rgranted, arb_owner, arb_err
    );

    modport slave (
        input  m_awff_rvalid, m_wbusy, m_we, m_wlast,
        input  m_arff_rvalid, m_rbusy, m_re, m_rlast,
        output wgranted, rgranted, arb_owner, arb_err
    );

endinterface

// File: rtl/asi_rw_arb.sv
// Burst-atomic arbiter for the single user-side memory port shared by asi_w and asi_r.
// Grants are combinational from the registered owner; a burst cap bounds back-to-back ownership.
module asi_rw_arb
    import asi_rw_arb_pkg::*;
#(
    parameter int ARB_POLICY = ARB_RR,
    parameter int MAX_BURSTS = 4
) (
    input  logic        usr_clk,
    input  logic        usr_reset_n,
    asi_rw_arb_if.slave bus
);

    localparam int              CNT_W = $clog2(MAX_BURSTS + 1);
    localparam logic [CNT_W:0]  CAP   = (CNT_W + 1)'(MAX_BURSTS);

    arb_owner_e       owner_q, owner_d;
    arb_owner_e       last_q, last_d;
    arb_owner_e       favor_q, favor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             wgrant, rgrant;
    logic             w_end, r_end;
    logic [CNT_W:0]   cnt_plus;
    logic             cap_hit;
    logic             err_now;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] nxt);
        return (nxt >= CAP) ? CAP[CNT_W-1:0] : nxt[CNT_W-1:0];
    endfunction

    assign w_end    = bus.m_we & bus.m_wlast;
    assign r_end    = bus.m_re & bus.m_rlast;
    assign cnt_plus = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cap_hit  = (cnt_plus >= CAP);

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_R;
            favor_q <= OWN_NONE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            favor_q <= favor_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        favor_d = favor_q;
        cnt_d   = cnt_q;
        err_d   = err_q | err_now;
        case (owner_q)
            OWN_NONE: begin
                if (wgrant && bus.m_wbusy) begin
                    owner_d = OWN_W;
                    last_d  = OWN_W;
                    favor_d = OWN_NONE;
                    cnt_d   = '0;
                end else if (rgrant && bus.m_rbusy) begin
                    owner_d = OWN_R;
                    last_d  = OWN_R;
                    favor_d = OWN_NONE;
                    cnt_d   = '0;
                end
            end
            OWN_W: begin
                if (w_end) cnt_d = sat_cnt(cnt_plus);
                if (w_end && bus.m_arff_rvalid && cap_hit) begin
                    owner_d = OWN_NONE;
                    favor_d = OWN_R;
                end else if (!bus.m_wbusy && (!bus.m_awff_rvalid || bus.m_arff_rvalid)) begin
                    // Idle, or stalled on W data while read is waiting: hand the port back.
                    owner_d = OWN_NONE;
                end
            end
            OWN_R: begin
                if (r_end) cnt_d = sat_cnt(cnt_plus);
                if (r_end && bus.m_awff_rvalid && cap_hit) begin
                    owner_d = OWN_NONE;
                    favor_d = OWN_W;
                end else if (!bus.m_rbusy && (!bus.m_arff_rvalid || bus.m_awff_rvalid)) begin
                    owner_d = OWN_NONE;
                end
            end
            default: owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        wgrant = 1'b0;
        rgrant = 1'b0;
        if (usr_reset_n) begin
            case (owner_q)
                OWN_NONE: begin
                    if (bus.m_awff_rvalid && bus.m_arff_rvalid) begin
                        if (tie_to_w(ARB_POLICY, favor_q, last_q)) wgrant = 1'b1;
                        else                                        rgrant = 1'b1;
                    end else begin
                        wgrant = bus.m_awff_rvalid;
                        rgrant = bus.m_arff_rvalid;
                    end
                end
                OWN_W:   wgrant = 1'b1;
                OWN_R:   rgrant = 1'b1;
                default: ;
            endcase
        end
    end

    assign err_now = (bus.m_wbusy & bus.m_rbusy)
                   | (bus.m_wbusy & ~wgrant & (owner_q != OWN_W))
                   | (bus.m_rbusy & ~rgrant & (owner_q != OWN_R))
                   | (bus.m_we & ~wgrant)
                   | (bus.m_re & ~rgrant);

    assign bus.wgranted  = wgrant;
    assign bus.rgranted  = rgrant;
    assign bus.arb_owner = owner_q;
    assign bus.arb_err   = err_q;

endmodule
